// File: rtl/dds_pkg.sv
// Shared constants and LFSR helper for the phase-accumulator DDS.
package dds_pkg;
    localparam int               PHASE_W   = 32;
    localparam int               AMP_FRAC  = 16;
    localparam logic [16:0]      AMP_UNITY = 17'h10000;
    localparam int               PIPE_LAT  = 5;
    localparam logic [31:0]      LFSR_SEED = 32'hACE1_2468;
    // Galois mask for x^32 + x^22 + x^2 + x + 1 (right-shifting form)
    localparam logic [31:0]      LFSR_TAPS = 32'h8020_0003;

    typedef logic [PHASE_W-1:0] phase_t;

    function automatic phase_t lfsr_next(input phase_t s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction
endpackage

// File: rtl/dds_sin_lut.sv
// Quarter-wave sine ROM with a one-cycle registered read; contents are computed at elaboration.
module dds_sin_lut #(
    parameter int LUT_AW = 10,
    parameter int OUT_W  = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [LUT_AW-1:0] addr,
    output logic [OUT_W-1:0]  data
);
    localparam longint PIO2_Q30 = 64'd1686629713;

    // Integer Taylor series in Q30, sampled at the centre of each quarter-wave bin
    function automatic longint sin_q30(input int i);
        longint x;
        longint x2;
        longint term;
        longint sum;
        x    = (PIO2_Q30 * longint'(2 * i + 1)) >>> (LUT_AW + 1);
        x2   = (x * x) >>> 30;
        term = x;
        sum  = x;
        for (int k = 1; k <= 7; k++) begin
            term = -((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1));
            sum  = sum + term;
        end
        return sum;
    endfunction

    function automatic logic [OUT_W-1:0] round_entry(input longint s);
        longint amax;
        longint v;
        amax = (longint'(1) <<< (OUT_W - 1)) - 1;
        v    = (s * amax + (longint'(1) <<< 29)) >>> 30;
        if (v > amax) v = amax;
        if (v < 0)    v = 0;
        return OUT_W'(v);
    endfunction

    logic [OUT_W-1:0] rom [2**LUT_AW];

    for (genvar g = 0; g < 2**LUT_AW; g++) begin : g_rom
        localparam logic [OUT_W-1:0] ENTRY = round_entry(sin_q30(g));
        assign rom[g] = ENTRY;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) data <= '0;
        else       data <= rom[addr];
    end
endmodule

// File: rtl/dds_core.sv
// Phase-accumulator DDS with quarter-wave LUT, 5-clock pipeline and amplitude scaling.
// Optional phase dither is enabled by defining DDS_DITHER_EN.
module dds_core
    import dds_pkg::*;
#(
    parameter int LUT_AW = 10,
    parameter int OUT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    word_wen,
    input  logic [31:0]             fword,
    input  logic [31:0]             pword,
    input  logic [31:0]             amp,
    input  logic                    en,
    input  logic                    phase_clr,
    output logic signed [OUT_W-1:0] dds_out,
    output logic                    out_valid
);
    localparam int PH_TOP = LUT_AW + 2;

    function automatic logic [16:0] clamp_amp(input logic [31:0] a);
        return (a >= 32'h0001_0000) ? AMP_UNITY : a[16:0];
    endfunction

    // Floor of (s * a) / 2^AMP_FRAC; |result| never exceeds |s|
    function automatic logic signed [OUT_W-1:0] scale_amp(input logic signed [OUT_W-1:0] s,
                                                          input logic [16:0] a);
        logic signed [OUT_W+17:0] prod;
        prod = s * $signed({1'b0, a});
        return OUT_W'(prod >>> AMP_FRAC);
    endfunction

    phase_t      fword_r, pword_r, acc;
    logic [31:0] amp_r;
    logic [PH_TOP-1:0] ph_top;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fword_r <= '0;
            pword_r <= '0;
            amp_r   <= '0;
        end else if (word_wen) begin
            fword_r <= fword;
            pword_r <= pword;
            amp_r   <= amp;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)          acc <= '0;
        else if (phase_clr) acc <= '0;
        else if (en)        acc <= acc + fword_r;
    end

`ifdef DDS_DITHER_EN
    phase_t lfsr;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)   lfsr <= LFSR_SEED;
        else if (en) lfsr <= lfsr_next(lfsr);
    end

    assign ph_top = PH_TOP'((acc + pword_r
                    + {{(PHASE_W-30+LUT_AW){1'b0}}, lfsr[29-LUT_AW:0]}) >> (PHASE_W - PH_TOP));
`else
    assign ph_top = PH_TOP'((acc + pword_r) >> (PHASE_W - PH_TOP));
`endif

    logic [1:0]              quad_p1;
    logic [LUT_AW-1:0]       idx_p1, addr_p2;
    logic [16:0]             amp_p1, amp_p2, amp_p3, amp_p4;
    logic                    neg_p2, neg_p3;
    logic [OUT_W-1:0]        lut_p3;
    logic signed [OUT_W-1:0] s_p4;
    logic                    vld_p1, vld_p2, vld_p3, vld_p4;

    // S1: phase offset and truncation
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            quad_p1 <= '0;
            idx_p1  <= '0;
            amp_p1  <= '0;
            vld_p1  <= 1'b0;
        end else begin
            quad_p1 <= ph_top[PH_TOP-1 -: 2];
            idx_p1  <= ph_top[LUT_AW-1:0];
            amp_p1  <= clamp_amp(amp_r);
            vld_p1  <= en;
        end
    end

    // S2: quadrant fold
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_p2 <= '0;
            neg_p2  <= 1'b0;
            amp_p2  <= '0;
            vld_p2  <= 1'b0;
        end else begin
            addr_p2 <= quad_p1[0] ? ~idx_p1 : idx_p1;
            neg_p2  <= quad_p1[1];
            amp_p2  <= amp_p1;
            vld_p2  <= vld_p1;
        end
    end

    // S3: ROM read
    dds_sin_lut #(.LUT_AW(LUT_AW), .OUT_W(OUT_W)) u_lut (
        .clk  (clk),
        .rstn (rstn),
        .addr (addr_p2),
        .data (lut_p3)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            neg_p3 <= 1'b0;
            amp_p3 <= '0;
            vld_p3 <= 1'b0;
        end else begin
            neg_p3 <= neg_p2;
            amp_p3 <= amp_p2;
            vld_p3 <= vld_p2;
        end
    end

    // S4: sign restore
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s_p4   <= '0;
            amp_p4 <= '0;
            vld_p4 <= 1'b0;
        end else begin
            s_p4   <= neg_p3 ? -$signed(lut_p3) : $signed(lut_p3);
            amp_p4 <= amp_p3;
            vld_p4 <= vld_p3;
        end
    end

    // S5: amplitude scaling
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dds_out   <= '0;
            out_valid <= 1'b0;
        end else begin
            dds_out   <= scale_amp(s_p4, amp_p4);
            out_valid <= vld_p4;
        end
    end
endmodule

// File: tb/tb_dds_core.sv
// Directed, table-driven bench for dds_core (default build, LUT_AW=10, OUT_W=16).
module tb_dds_core;
    logic               clk = 1'b0;
    logic               rstn;
    logic               word_wen;
    logic [31:0]        fword, pword, amp;
    logic               en;
    logic               phase_clr;
    logic signed [15:0] dds_out;
    logic               out_valid;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] fword;
        logic [31:0] pword;
        logic [31:0] amp;
        int          e [4];
    } vec_t;

    vec_t vecs [8];

    dds_core #(.LUT_AW(10), .OUT_W(16)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .word_wen  (word_wen),
        .fword     (fword),
        .pword     (pword),
        .amp       (amp),
        .en        (en),
        .phase_clr (phase_clr),
        .dds_out   (dds_out),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic [31:0] f, input logic [31:0] p,
                           input logic [31:0] a, input int e0, input int e1,
                           input int e2, input int e3);
        vecs[i].fword = f;
        vecs[i].pword = p;
        vecs[i].amp   = a;
        vecs[i].e[0]  = e0;
        vecs[i].e[1]  = e1;
        vecs[i].e[2]  = e2;
        vecs[i].e[3]  = e3;
    endtask

    // Load tuning words, clear phase, drain, then enable and check the first 4 valid samples.
    task automatic run_row(input int i);
        bit got;
        en        = 1'b0;
        word_wen  = 1'b1;
        fword     = vecs[i].fword;
        pword     = vecs[i].pword;
        amp       = vecs[i].amp;
        tick();
        word_wen  = 1'b0;
        phase_clr = 1'b1;
        tick();
        phase_clr = 1'b0;
        repeat (6) tick();
        en  = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 12 && !got; c++) begin
            tick();
            got = out_valid;
        end
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL row%0d_valid_timeout: out_valid never rose", i);
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (k > 0) tick();
                check($sformatf("row%0d_s%0d", i, k), dds_out, vecs[i].e[k]);
            end
        end
    endtask

    initial begin
        int pat [4];
        pat[0] = 25; pat[1] = 32767; pat[2] = -25; pat[3] = -32767;

        set_vec(0, 32'h4000_0000, 32'h0,         32'h0001_0000, 25, 32767, -25, -32767);
        set_vec(1, 32'h4000_0000, 32'h0,         32'h0000_8000, 12, 16383, -13, -16384);
        set_vec(2, 32'h4000_0000, 32'h0,         32'h0003_0000, 25, 32767, -25, -32767);
        set_vec(3, 32'h0,         32'h4000_0000, 32'h0001_0000, 32767, 32767, 32767, 32767);
        set_vec(4, 32'h4000_0000, 32'h0,         32'h0,         0, 0, 0, 0);
        set_vec(5, 32'h8000_0000, 32'h0,         32'h0001_0000, 25, -25, 25, -25);
        set_vec(6, 32'h4000_0000, 32'h0,         32'h0000_0001, 0, 0, -1, -1);
        set_vec(7, 32'h4000_0000, 32'h0,         32'h0000_FFFF, 24, 32766, -25, -32767);

        // Reset held with en=1
        rstn = 1'b0; word_wen = 1'b0; fword = '0; pword = '0; amp = '0;
        en = 1'b1; phase_clr = 1'b0;
        repeat (3) tick();
        check("rst_dds_out", dds_out, 0);
        check("rst_out_valid", out_valid, 0);
        rstn = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check($sformatf("post_rst_valid_c%0d", i), out_valid, (i == 5) ? 1 : 0);
        end
        check("post_rst_dds_out", dds_out, 0);

        for (int i = 0; i < 8; i++) run_row(i);

        // phase_clr with fword=0 keeps a constant output
        run_row(3);
        phase_clr = 1'b1;
        tick();
        phase_clr = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            check($sformatf("clr_const_c%0d", k), dds_out, 32767);
        end

        // Mid-stream amplitude change; output after the last row_0 sample was pat[3]
        run_row(0);
        word_wen = 1'b1;
        fword    = 32'h4000_0000;
        pword    = 32'h0;
        amp      = 32'h0;
        for (int j = 1; j <= 6; j++) begin
            tick();
            word_wen = 1'b0;
            check($sformatf("amp_chg_j%0d", j), dds_out, (j == 6) ? 0 : pat[(3 + j) % 4]);
        end

        // Accumulator wrap, hold and clear priority
        en       = 1'b0;
        word_wen = 1'b1;
        fword    = 32'hFFFF_FFFF;
        amp      = 32'h0001_0000;
        tick();
        word_wen  = 1'b0;
        phase_clr = 1'b1;
        tick();
        phase_clr = 1'b0;
        en        = 1'b1;
        repeat (3) tick();
        en = 1'b0;
        check("acc_wrap", dut.acc, 32'hFFFF_FFFD);
        tick();
        check("acc_hold", dut.acc, 32'hFFFF_FFFD);
        en        = 1'b1;
        phase_clr = 1'b1;
        tick();
        phase_clr = 1'b0;
        en        = 1'b0;
        check("acc_clr_wins", dut.acc, 0);

        // Asynchronous reset mid-run
        run_row(0);
        #2;
        rstn = 1'b0;
        #1;
        check("async_rst_dds_out", dds_out, 0);
        check("async_rst_valid", out_valid, 0);
        tick();
        rstn = 1'b1;
        en   = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
